// File: rtl/fb_sched_pkg.sv
// Shared types and defaults for the frame-buffer background scheduler.
// Holds the sequencer state enum, default geometry and width helpers.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BKG,
    SPR,
    DONE
  } state_t;

  localparam int DEF_H_PIX   = 320;
  localparam int DEF_V_PIX   = 240;
  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_COLOR_W = 4;

  // Counter width for a 0..n-1 count; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_COL_W = cnt_w(DEF_H_PIX);
  localparam int DEF_ROW_W = cnt_w(DEF_V_PIX);

endpackage

// File: rtl/fb_col_ctr.sv
// Enable-gated column counter 0..H_PIX-1 with terminal flag and wrap.
// Ports: clk, aresetn, clr (sync clear), en (advance), col, tc (col==H_PIX-1).
module fb_col_ctr
  import fb_sched_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX,
  parameter int COL_W = cnt_w(DEF_H_PIX)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic             tc
);

  assign tc = (col == COL_W'(H_PIX - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      col <= '0;
    end else if (clr) begin
      col <= '0;
    end else if (en) begin
      col <= tc ? '0 : col + COL_W'(1);
    end
  end

endmodule

// File: rtl/fb_bkg_scheduler.sv
// Per-frame FB write sequencer: background fill, then one sprite grant.
// Ports: clk, aresetn, frame_start, bkg_color, fb_ready, spr_req, spr_done
//   in; fb_we, fb_addr, fb_wdata, spr_gnt, busy, frame_done, overrun out.
module fb_bkg_scheduler
  import fb_sched_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_PIX   = DEF_V_PIX,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               frame_start,
  input  logic [COLOR_W-1:0] bkg_color,
  input  logic               fb_ready,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               spr_req,
  output logic               spr_gnt,
  input  logic               spr_done,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int COL_W = cnt_w(H_PIX);
  localparam int ROW_W = cnt_w(V_PIX);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             col_tc;
  logic             accept;
  logic             last_px;

  assign accept  = (state == BKG) && fb_we && fb_ready;
  assign last_px = col_tc && (row == ROW_W'(V_PIX - 1));

  fb_col_ctr #(
    .H_PIX(H_PIX),
    .COL_W(COL_W)
  ) u_col (
    .clk    (clk),
    .aresetn(aresetn),
    .clr    (state == IDLE),
    .en     (accept),
    .col    (col),
    .tc     (col_tc)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      row        <= '0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_we      <= 1'b0;
      spr_gnt    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= frame_start && (state != IDLE);
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          row     <= '0;
          fb_addr <= '0;
          if (frame_start) begin
            fb_wdata <= bkg_color;
            fb_we    <= 1'b1;
            busy     <= 1'b1;
            state    <= BKG;
          end
        end
        BKG: begin
          if (accept) begin
            fb_addr <= fb_addr + ADDR_W'(1);
            if (last_px) begin
              fb_we <= 1'b0;
              state <= SPR;
            end else if (col_tc) begin
              row <= row + ROW_W'(1);
            end
          end
        end
        SPR: begin
          // Only the entry cycle is ungranted; decide there.
          if (spr_gnt) begin
            if (spr_done) begin
              spr_gnt    <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end else if (spr_req) begin
            spr_gnt <= 1'b1;
          end else begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bkg_scheduler.sv
// Directed bench for fb_bkg_scheduler on a 4x3 frame.
// Covers fill, stalls, sprite grant, overrun, abort and back-to-back frames.
module tb_fb_bkg_scheduler;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  bkg_color = 4'h0;
  logic        fb_ready = 1'b1;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [3:0]  fb_wdata;
  logic        spr_req = 1'b0;
  logic        spr_gnt;
  logic        spr_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int fd_cyc[$];

  fb_bkg_scheduler #(
    .H_PIX(4),
    .V_PIX(3),
    .ADDR_W(17),
    .COLOR_W(4)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .frame_start(frame_start),
    .bkg_color  (bkg_color),
    .fb_ready   (fb_ready),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .spr_req    (spr_req),
    .spr_gnt    (spr_gnt),
    .spr_done   (spr_done),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (aresetn && fb_we && fb_ready) begin
        wr_addr.push_back(int'(fb_addr));
        wr_data.push_back(int'(fb_wdata));
        wr_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (overrun) ov_cnt++;
      if (fb_we && spr_gnt) both_cnt++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    fd_cyc.delete();
    ov_cnt = 0;
    both_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] c);
    frame_start = 1'b1;
    bkg_color = c;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n);
    end
  endtask

  task automatic check_fill(input string nm, input int base,
                            input int color);
    total++;
    if (wr_addr.size() < base + 12) begin
      bad++;
      $display("FAIL %s_count: writes=%0d need %0d", nm,
               wr_addr.size(), base + 12);
    end
    for (int i = base; i < wr_addr.size() && i < base + 12; i++) begin
      total++;
      if (wr_addr[i] !== i - base || wr_data[i] !== color) begin
        bad++;
        $display("FAIL %s_wr%0d: addr=%0d data=%h need addr=%0d data=%h",
                 nm, i, wr_addr[i], wr_data[i], i - base, color);
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    tick();
    total++;
    if ({fb_we, spr_gnt, busy, frame_done, overrun} !== 5'b0 ||
        fb_addr !== 17'd0 || fb_wdata !== 4'h0) begin
      bad++;
      $display("FAIL reset: we=%b gnt=%b busy=%b fd=%b ov=%b a=%0d d=%h need 0",
               fb_we, spr_gnt, busy, frame_done, overrun, fb_addr, fb_wdata);
    end
    aresetn = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || fb_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b we=%b need 0 0", busy, fb_we);
    end
  endtask

  task automatic test_basic();
    clear_log();
    fb_ready = 1'b1;
    spr_req = 1'b0;
    start_frame(4'hA);
    total++;
    if (fb_we !== 1'b1 || fb_addr !== 17'd0 || fb_wdata !== 4'hA ||
        busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_start: we=%b a=%0d d=%h busy=%b need 1 0 a 1",
               fb_we, fb_addr, fb_wdata, busy);
    end
    wait_idle(40);
    check_fill("basic", 0, 4'hA);
    if (wr_cyc.size() == 12) begin
      total++;
      if (wr_cyc[11] - wr_cyc[0] !== 11) begin
        bad++;
        $display("FAIL basic_consec: span=%0d need 11",
                 wr_cyc[11] - wr_cyc[0]);
      end
      total++;
      if (fd_cyc.size() !== 1 || fd_cyc[0] !== wr_cyc[11] + 2) begin
        bad++;
        $display("FAIL basic_done: n=%0d at=%0d need 1 at %0d",
                 fd_cyc.size(), fd_cyc.size() ? fd_cyc[0] : -1,
                 wr_cyc[11] + 2);
      end
    end
    total++;
    if (ov_cnt !== 0) begin
      bad++;
      $display("FAIL basic_ov: overruns=%0d need 0", ov_cnt);
    end
  endtask

  task automatic test_stall();
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_a = 0;
    int k = 0;
    clear_log();
    start_frame(4'h3);
    while (busy && k < 80) begin
      if (fb_we) begin
        total++;
        if (fb_addr !== 17'(exp_a)) begin
          bad++;
          $display("FAIL stall_addr%0d: addr=%0d need %0d", k, fb_addr, exp_a);
        end
      end
      fb_ready = pat[k % 4];
      if (fb_we && fb_ready) exp_a++;
      tick();
      k++;
    end
    fb_ready = 1'b1;
    wait_idle(10);
    check_fill("stall", 0, 4'h3);
    total++;
    if (exp_a !== 12) begin
      bad++;
      $display("FAIL stall_accepts: accepted=%0d need 12", exp_a);
    end
  endtask

  task automatic test_sprite();
    int k = 0;
    int g;
    clear_log();
    spr_req = 1'b1;
    start_frame(4'h7);
    while (!spr_gnt && k < 40) begin
      tick();
      k++;
    end
    g = cyc;
    total++;
    if (spr_gnt !== 1'b1 || fb_we !== 1'b0 || wr_cyc.size() != 12 ||
        g !== wr_cyc[wr_cyc.size() - 1] + 1) begin
      bad++;
      $display("FAIL spr_rise: gnt=%b we=%b writes=%0d edge=%0d",
               spr_gnt, fb_we, wr_cyc.size(), g);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) spr_req = 1'b0;
      total++;
      if (spr_gnt !== 1'b1 || fb_we !== 1'b0) begin
        bad++;
        $display("FAIL spr_hold%0d: gnt=%b we=%b need 1 0", i, spr_gnt, fb_we);
      end
    end
    spr_done = 1'b1;
    tick();
    spr_done = 1'b0;
    total++;
    if (spr_gnt !== 1'b0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL spr_drop: gnt=%b fd=%b need 0 1", spr_gnt, frame_done);
    end
    wait_idle(10);
    check_fill("spr", 0, 4'h7);
    total++;
    if (fd_cyc.size() !== 1 || both_cnt !== 0) begin
      bad++;
      $display("FAIL spr_done_cnt: fd=%0d we_and_gnt=%0d need 1 0",
               fd_cyc.size(), both_cnt);
    end
  endtask

  task automatic test_overrun();
    int k = 0;
    clear_log();
    start_frame(4'h5);
    while (fb_addr != 17'd5 && k < 30) begin
      tick();
      k++;
    end
    frame_start = 1'b1;
    bkg_color = 4'hC;
    tick();
    frame_start = 1'b0;
    total++;
    if (overrun !== 1'b1 || fb_wdata !== 4'h5) begin
      bad++;
      $display("FAIL ov_pulse: ov=%b d=%h need 1 5", overrun, fb_wdata);
    end
    tick();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ov_width: ov=%b need 0", overrun);
    end
    wait_idle(30);
    repeat (6) tick();
    check_fill("ov", 0, 4'h5);
    total++;
    if (wr_addr.size() !== 12 || busy !== 1'b0 || ov_cnt !== 1 ||
        fd_cyc.size() !== 1) begin
      bad++;
      $display("FAIL ov_nosecond: writes=%0d busy=%b ov=%0d fd=%0d need 12 0 1 1",
               wr_addr.size(), busy, ov_cnt, fd_cyc.size());
    end
  endtask

  task automatic test_abort();
    int k = 0;
    clear_log();
    start_frame(4'hE);
    while (fb_addr != 17'd7 && k < 30) begin
      tick();
      k++;
    end
    aresetn = 1'b0;
    #1;
    total++;
    if ({fb_we, spr_gnt, busy, frame_done, overrun} !== 5'b0 ||
        fb_addr !== 17'd0 || fb_wdata !== 4'h0) begin
      bad++;
      $display("FAIL abort_rst: we=%b busy=%b a=%0d d=%h need 0 0 0 0",
               fb_we, busy, fb_addr, fb_wdata);
    end
    tick();
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    total++;
    if (fd_cyc.size() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone: fd=%0d busy=%b need 0 0",
               fd_cyc.size(), busy);
    end
    clear_log();
    start_frame(4'h6);
    wait_idle(40);
    check_fill("abort_new", 0, 4'h6);
  endtask

  task automatic test_back_to_back();
    clear_log();
    start_frame(4'h9);
    wait_idle(40);
    start_frame(4'h2);
    wait_idle(40);
    check_fill("b2b_a", 0, 4'h9);
    check_fill("b2b_b", 12, 4'h2);
    total++;
    if (ov_cnt !== 0 || fd_cyc.size() !== 2) begin
      bad++;
      $display("FAIL b2b_flags: ov=%0d fd=%0d need 0 2", ov_cnt, fd_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_sprite();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
